// File: rtl/grid_bank_pkg.sv
// rtl/grid_bank_pkg.sv - bank geometry, chunk/op types and address helpers for grid_bank_server
package grid_bank_pkg;

   localparam int TX_W           = 64;
   localparam int ROW_W          = 192;
   localparam int DEPTH          = 140;
   localparam int CHUNKS_PER_ROW = ROW_W / TX_W;
   localparam int ROW_AW         = $clog2(DEPTH + 1);
   localparam int COL_AW         = $clog2(ROW_W);
   localparam int OFF_W          = $clog2(TX_W);
   localparam int CIDX_W         = (CHUNKS_PER_ROW > 1) ? $clog2(CHUNKS_PER_ROW) : 1;
   localparam int MEM_WORDS      = DEPTH * CHUNKS_PER_ROW;
   localparam int MEM_AW         = $clog2(MEM_WORDS);

   typedef logic [TX_W-1:0] chunk_t;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_READ,
      OP_WRITE
   } req_op_e;

   function automatic logic [CIDX_W-1:0] chunk_index(input logic [COL_AW-1:0] col);
      return CIDX_W'(col >> OFF_W);
   endfunction

   // Row DEPTH is the padding row: addressable, never stored.
   function automatic logic row_in_bank(input logic [ROW_AW-1:0] row);
      return row < ROW_AW'(DEPTH);
   endfunction

   function automatic logic col_valid(input logic [COL_AW-1:0] col);
      return ({1'b0, col} < (COL_AW + 1)'(ROW_W)) && (col[OFF_W-1:0] == '0);
   endfunction

   function automatic logic [MEM_AW-1:0] mem_index(input logic [ROW_AW-1:0] row,
                                                   input logic [COL_AW-1:0] col);
      return MEM_AW'(row) * MEM_AW'(CHUNKS_PER_ROW) + MEM_AW'(chunk_index(col));
   endfunction

endpackage

// File: rtl/grid_bank_server_if.sv
// rtl/grid_bank_server_if.sv - worker request/ack bus and host load port of the grid bank
interface grid_bank_server_if import grid_bank_pkg::*; #(
   parameter int NUM_REQ = 2
);

   logic [NUM_REQ-1:0]        req_read_en;
   logic [NUM_REQ-1:0]        req_write_en;
   logic [NUM_REQ*ROW_AW-1:0] req_row_addr;
   logic [NUM_REQ*COL_AW-1:0] req_col_addr;
   logic [NUM_REQ*TX_W-1:0]   req_wdata;
   logic [NUM_REQ-1:0]        ack_out;
   chunk_t                    rdata_out;
   logic                      load_en;
   logic [ROW_AW-1:0]         load_row;
   logic [COL_AW-1:0]         load_col;
   chunk_t                    load_data;

   modport master (
      output req_read_en, req_write_en, req_row_addr, req_col_addr, req_wdata,
      output load_en, load_row, load_col, load_data,
      input  ack_out, rdata_out
   );

   modport slave (
      input  req_read_en, req_write_en, req_row_addr, req_col_addr, req_wdata,
      input  load_en, load_row, load_col, load_data,
      output ack_out, rdata_out
   );

endinterface

// File: rtl/grid_rr_arbiter.sv
// rtl/grid_rr_arbiter.sv - round-robin arbiter: request mask in, one-hot grant out
module grid_rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_nxt;
   logic             found;
   int               idx;

   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_nxt    = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) ptr <= '0;
      else          ptr <= ptr_nxt;
   end

endmodule

// File: rtl/grid_bank_server.sv
// rtl/grid_bank_server.sv - row/column chunk bank serving NUM_REQ workers plus a host load port
// Optional statistics outputs are built when GRID_BANK_STATS_EN is defined.
module grid_bank_server import grid_bank_pkg::*; #(
   parameter int NUM_REQ = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   grid_bank_server_if.slave bus,
`ifdef GRID_BANK_STATS_EN
   output logic [31:0]       stat_reads_out,
   output logic [31:0]       stat_writes_out,
   output logic [31:0]       stat_stall_out,
`endif
   output logic              addr_err_out
);

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] arb_req;
   logic [NUM_REQ-1:0] grant;
   req_op_e            g_op;
   logic [ROW_AW-1:0]  g_row;
   logic [COL_AW-1:0]  g_col;
   chunk_t             g_wdata;
   logic               g_in_range;
   logic               g_err;
   logic [MEM_AW-1:0]  g_mem_idx;
   logic               ld_in_range;
   logic               ld_err;
   logic [MEM_AW-1:0]  ld_mem_idx;
   chunk_t             mem [MEM_WORDS];

   // A port whose ack is high this cycle may be mid-update, so it sits out one round.
   assign elig    = (bus.req_read_en | bus.req_write_en) & ~bus.ack_out;
   assign arb_req = bus.load_en ? '0 : elig;

   grid_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (arb_req),
      .grant   (grant)
   );

   always_comb begin
      g_op    = OP_NONE;
      g_row   = '0;
      g_col   = '0;
      g_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            g_op    = bus.req_write_en[i] ? OP_WRITE : OP_READ;
            g_row   = bus.req_row_addr[i*ROW_AW +: ROW_AW];
            g_col   = bus.req_col_addr[i*COL_AW +: COL_AW];
            g_wdata = bus.req_wdata[i*TX_W +: TX_W];
         end
      end
   end

   // Rows past the bank only read zero; only a bad column raises the error flag.
   assign g_in_range  = row_in_bank(g_row) && col_valid(g_col);
   assign g_err       = (g_op != OP_NONE) && !col_valid(g_col);
   assign g_mem_idx   = g_in_range ? mem_index(g_row, g_col) : '0;

   assign ld_in_range = row_in_bank(bus.load_row) && col_valid(bus.load_col);
   assign ld_err      = bus.load_en && !ld_in_range;
   assign ld_mem_idx  = ld_in_range ? mem_index(bus.load_row, bus.load_col) : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.ack_out   <= '0;
         bus.rdata_out <= '0;
         addr_err_out  <= 1'b0;
      end else begin
         bus.ack_out <= grant;
         if (g_op == OP_READ)
            bus.rdata_out <= g_in_range ? mem[g_mem_idx] : '0;
         if (g_err || ld_err)
            addr_err_out <= 1'b1;
      end
   end

   // Bank contents survive reset; load and granted write never coincide.
   always_ff @(posedge clock) begin
      if (bus.load_en && ld_in_range)
         mem[ld_mem_idx] <= bus.load_data;
      else if (g_op == OP_WRITE && g_in_range)
         mem[g_mem_idx] <= g_wdata;
   end

`ifdef GRID_BANK_STATS_EN
   req_op_e ack_op;
   logic    stall;

   assign stall = |(elig & ~grant);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ack_op          <= OP_NONE;
         stat_reads_out  <= '0;
         stat_writes_out <= '0;
         stat_stall_out  <= '0;
      end else begin
         ack_op <= g_op;
         if (ack_op == OP_READ && stat_reads_out != '1)
            stat_reads_out <= stat_reads_out + 32'd1;
         if (ack_op == OP_WRITE && stat_writes_out != '1)
            stat_writes_out <= stat_writes_out + 32'd1;
         if (stall && stat_stall_out != '1)
            stat_stall_out <= stat_stall_out + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_grid_bank_server.sv
// tb/tb_grid_bank_server.sv - scoreboard bench for grid_bank_server
module tb_grid_bank_server;
   import grid_bank_pkg::*;

   localparam int NUM_REQ = 2;

   typedef struct {
      bit     rd;
      chunk_t data;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic addr_err_out;
`ifdef GRID_BANK_STATS_EN
   logic [31:0] stat_reads_out;
   logic [31:0] stat_writes_out;
   logic [31:0] stat_stall_out;
`endif

   grid_bank_server_if #(.NUM_REQ(NUM_REQ)) bus ();

   grid_bank_server #(.NUM_REQ(NUM_REQ)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .bus             (bus),
`ifdef GRID_BANK_STATS_EN
      .stat_reads_out  (stat_reads_out),
      .stat_writes_out (stat_writes_out),
      .stat_stall_out  (stat_stall_out),
`endif
      .addr_err_out    (addr_err_out)
   );

   always #5 clock = ~clock;

   exp_t               sb [NUM_REQ][$];
   int                 ack_port_q[$];
   int                 ack_cyc_q[$];
   logic [NUM_REQ-1:0] ack_seen = '0;
   chunk_t             last_rd  = '0;
   int                 n_vec    = 0;
   int                 n_err    = 0;
   int                 cyc      = 0;
   chunk_t             row3 [3] = '{64'hA1A1_0000_0000_000A, 64'hB2B2_0000_0000_000B,
                                    64'hC3C3_0000_0000_000C};

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance to the next falling edge and score any ack seen there.
   task automatic step();
      exp_t e;
      @(negedge clock);
      cyc++;
      ack_seen = bus.ack_out;
      if (bus.ack_out != '0) begin
         check_eq("ack_onehot", 64'($countones(bus.ack_out)), 64'd1);
         for (int p = 0; p < NUM_REQ; p++) begin
            if (bus.ack_out[p]) begin
               ack_port_q.push_back(p);
               ack_cyc_q.push_back(cyc);
               if (sb[p].size() == 0) begin
                  check_eq("spurious_ack", 64'(bus.ack_out), 64'd0);
               end else begin
                  e = sb[p].pop_front();
                  if (e.rd) begin
                     check_eq("rdata", bus.rdata_out, e.data);
                     last_rd = e.data;
                  end else begin
                     check_eq("rdata_hold", bus.rdata_out, last_rd);
                  end
               end
            end
         end
      end
   endtask

   task automatic issue(input int p, input bit wr, input bit rd, input int row, input int col,
                        input chunk_t wd, input chunk_t exp_data);
      exp_t e;
      bus.req_write_en[p]                  = wr;
      bus.req_read_en[p]                   = rd;
      bus.req_row_addr[p*ROW_AW +: ROW_AW] = ROW_AW'(row);
      bus.req_col_addr[p*COL_AW +: COL_AW] = COL_AW'(col);
      bus.req_wdata[p*TX_W +: TX_W]        = wd;
      e.rd   = !wr;
      e.data = exp_data;
      sb[p].push_back(e);
   endtask

   task automatic drop_req(input int p);
      bus.req_write_en[p] = 1'b0;
      bus.req_read_en[p]  = 1'b0;
   endtask

   task automatic wait_ack(input int p, output int lat);
      lat = 0;
      do begin
         step();
         lat++;
      end while (!ack_seen[p] && lat < 40);
      if (!ack_seen[p]) check_eq("ack_timeout", 64'(ack_seen[p]), 64'd1);
   endtask

   task automatic load(input int row, input int col, input chunk_t d);
      bus.load_en   = 1'b1;
      bus.load_row  = ROW_AW'(row);
      bus.load_col  = COL_AW'(col);
      bus.load_data = d;
      step();
   endtask

   task automatic reset_pulse();
      reset_n     = 1'b0;
      bus.load_en = 1'b0;
      for (int p = 0; p < NUM_REQ; p++) begin
         drop_req(p);
         sb[p].delete();
      end
      last_rd = '0;
      repeat (2) step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      int lat;
      int n0;
      int n1;
      bus.req_read_en  = '0;
      bus.req_write_en = '0;
      bus.req_row_addr = '0;
      bus.req_col_addr = '0;
      bus.req_wdata    = '0;
      bus.load_en      = 1'b0;
      bus.load_row     = '0;
      bus.load_col     = '0;
      bus.load_data    = '0;

      repeat (3) step();
      check_eq("rst_ack", 64'(bus.ack_out), 64'd0);
      check_eq("rst_rdata", bus.rdata_out, 64'd0);
      check_eq("rst_err", 64'(addr_err_out), 64'd0);
      reset_n = 1'b1;
      step();

      for (int c = 0; c < 3; c++) load(3, c * TX_W, row3[c]);
      bus.load_en = 1'b0;

      // back-to-back reads from one port: one op every two cycles
      issue(0, 1'b0, 1'b1, 3, 0, '0, row3[0]);
      wait_ack(0, lat);
      check_eq("b2b_lat_first", 64'(lat), 64'd1);
      for (int c = 1; c < 3; c++) begin
         issue(0, 1'b0, 1'b1, 3, c * TX_W, '0, row3[c]);
         wait_ack(0, lat);
         check_eq("b2b_lat", 64'(lat), 64'd2);
      end
      drop_req(0);
      repeat (3) step();

      // padding row reads zero without raising the error flag
      issue(1, 1'b0, 1'b1, DEPTH, 0, '0, '0);
      wait_ack(1, lat);
      drop_req(1);
      step();
      check_eq("pad_err", 64'(addr_err_out), 64'd0);

      // both ports contend continuously: grants alternate every cycle
      ack_port_q.delete();
      ack_cyc_q.delete();
      issue(0, 1'b0, 1'b1, 3, 0, '0, row3[0]);
      issue(1, 1'b0, 1'b1, 3, 2 * TX_W, '0, row3[2]);
      n0 = 1;
      n1 = 1;
      for (int k = 0; k < 30 && ack_port_q.size() < 6; k++) begin
         step();
         if (ack_seen[0]) begin
            if (n0 < 3) begin
               issue(0, 1'b0, 1'b1, 3, n0 * TX_W, '0, row3[n0]);
               n0++;
            end else drop_req(0);
         end
         if (ack_seen[1]) begin
            if (n1 < 3) begin
               issue(1, 1'b0, 1'b1, 3, (2 - n1) * TX_W, '0, row3[2 - n1]);
               n1++;
            end else drop_req(1);
         end
      end
      drop_req(0);
      drop_req(1);
      check_eq("rr_count", 64'(ack_port_q.size()), 64'd6);
      for (int k = 0; k < ack_port_q.size() && k < 6; k++)
         check_eq("rr_order", 64'(ack_port_q[k]), 64'(k % 2));
      if (ack_port_q.size() == 6)
         check_eq("rr_span", 64'(ack_cyc_q[5] - ack_cyc_q[0]), 64'd5);
      repeat (2) step();

      // write beats read on the same port, then read back from the other port
      issue(1, 1'b1, 1'b1, 5, 64, 64'hDEAD, '0);
      wait_ack(1, lat);
      drop_req(1);
      repeat (3) step();
      issue(0, 1'b0, 1'b1, 5, 64, '0, 64'hDEAD);
      wait_ack(0, lat);
      check_eq("wr_rd_lat", 64'(lat), 64'd1);
      drop_req(0);
      step();

      // misaligned read returns zero and sets the sticky flag
      issue(0, 1'b0, 1'b1, 3, 32, '0, '0);
      wait_ack(0, lat);
      drop_req(0);
      check_eq("misalign_err", 64'(addr_err_out), 64'd1);
      step();

      // host load blocks grants for as long as it is held
      issue(0, 1'b0, 1'b1, 7, 128, '0, 64'h7777_1234_5678_9ABC);
      bus.load_en   = 1'b1;
      bus.load_row  = ROW_AW'(7);
      bus.load_col  = COL_AW'(128);
      bus.load_data = 64'h7777_1234_5678_9ABC;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("load_block", 64'(ack_seen[0]), 64'd0);
      end
      bus.load_en = 1'b0;
      wait_ack(0, lat);
      check_eq("load_release_lat", 64'(lat), 64'd1);
      drop_req(0);
      step();

      // reset during an ack clears outputs at once but keeps the bank
      issue(0, 1'b0, 1'b1, 3, 64, '0, row3[1]);
      wait_ack(0, lat);
      #1 reset_n = 1'b0;
      #1;
      check_eq("rst_async_ack", 64'(bus.ack_out), 64'd0);
      check_eq("rst_async_rdata", bus.rdata_out, 64'd0);
      drop_req(0);
      last_rd = '0;
      repeat (2) step();
      reset_n = 1'b1;
      check_eq("rst_err_clr", 64'(addr_err_out), 64'd0);
      step();

      // pointer restarts at port 0 after reset
      ack_port_q.delete();
      issue(0, 1'b0, 1'b1, 3, 128, '0, row3[2]);
      issue(1, 1'b0, 1'b1, 5, 64, '0, 64'hDEAD);
      for (int k = 0; k < 10 && ack_port_q.size() < 2; k++) begin
         step();
         if (ack_seen[0]) drop_req(0);
         if (ack_seen[1]) drop_req(1);
      end
      drop_req(0);
      drop_req(1);
      check_eq("rst_ptr_count", 64'(ack_port_q.size()), 64'd2);
      if (ack_port_q.size() > 0)
         check_eq("rst_ptr_first", 64'(ack_port_q[0]), 64'd0);
      step();

      // column past the row end: zero data, flag set
      issue(1, 1'b0, 1'b1, 3, ROW_W, '0, '0);
      wait_ack(1, lat);
      drop_req(1);
      check_eq("col_oob_err", 64'(addr_err_out), 64'd1);
      step();

      // misaligned write is dropped
      issue(1, 1'b1, 1'b0, 3, 96, 64'hBAD0_BAD0, '0);
      wait_ack(1, lat);
      drop_req(1);
      step();
      issue(0, 1'b0, 1'b1, 3, 64, '0, row3[1]);
      wait_ack(0, lat);
      drop_req(0);
      step();

      // out-of-range and misaligned loads are dropped and flagged
      reset_pulse();
      check_eq("rst2_err", 64'(addr_err_out), 64'd0);
      load(3, 8, 64'h0BAD_0BAD);
      bus.load_en = 1'b0;
      step();
      check_eq("load_misalign_err", 64'(addr_err_out), 64'd1);
      reset_pulse();
      load(DEPTH, 0, 64'h0BAD_0BAD);
      bus.load_en = 1'b0;
      step();
      check_eq("load_oob_err", 64'(addr_err_out), 64'd1);
      issue(0, 1'b0, 1'b1, 3, 0, '0, row3[0]);
      wait_ack(0, lat);
      drop_req(0);
      repeat (3) step();

      for (int p = 0; p < NUM_REQ; p++)
         check_eq("sb_drained", 64'(sb[p].size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1);
   end

endmodule

// File: doc/grid_bank_server.md
Name: grid_bank_server

Overview:
- Responder end of the row/column chunk memory interface that grid worker machines drive as initiators (read_en/write_en, row/col address, chunk data, ack).
- Holds one bank of grid rows; each row is ROW_W bits, accessed as TX_W-bit chunks.
- Arbitrates NUM_REQ worker ports round-robin and returns single-cycle ack pulses with read data.
- Has a host load port for initial fill.

Parameters:
- NUM_REQ, 2, number of worker initiator ports.
- TX_W, 64, chunk width in bits; power of two.
- ROW_W, 192, row width in bits; multiple of TX_W.
- DEPTH, 140, rows held in the bank.
- ROW_AW, $clog2(DEPTH+1), row address width.
- COL_AW, $clog2(ROW_W), column (bit offset) address width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_read_en  in  NUM_REQ  per-port read request, held until acked.
- req_write_en  in  NUM_REQ  per-port write request, held until acked.
- req_row_addr  in  NUM_REQ*ROW_AW  per-port row address.
- req_col_addr  in  NUM_REQ*COL_AW  per-port bit offset of the chunk; TX_W-aligned.
- req_wdata  in  NUM_REQ*TX_W  per-port write chunk.
- ack_out  out  NUM_REQ  one-hot-or-zero, single-cycle completion pulse.
- rdata_out  out  TX_W  shared read data; valid only in a cycle where ack_out is nonzero and the acked op was a read.
- load_en  in  1  host load strobe; always accepted, no ack.
- load_row  in  ROW_AW  host row.
- load_col  in  COL_AW  host bit offset.
- load_data  in  TX_W  host chunk.
- addr_err_out  out  1  sticky out-of-range or misaligned access flag.

Behaviour:
- Reset (async assert, sync deassert): ack_out=0, rdata_out=0, addr_err_out=0, round-robin pointer=0, all pending state cleared. Bank contents are not reset and persist across reset.
- Eligibility: port i is eligible in cycle t if (req_write_en[i] | req_read_en[i]) and ack_out[i]==0 in cycle t. This prevents re-serving a request whose address the initiator updates on the ack edge.
- Write beats read when both are asserted on the same port.
- Grant: at most one port per cycle, chosen by round-robin starting at the pointer. On a grant to port g, the pointer becomes (g+1) mod NUM_REQ. No grant occurs in any cycle with load_en=1.
- Latency: grant in cycle t gives ack_out[g]=1 in cycle t+1.
  - Read: rdata_out in t+1 = chunk at (row, col/TX_W) sampled at the t edge.
  - Write: array updated at the end of cycle t, so a read granted in t+1 sees the new data.
- Per-port throughput: at most one op per 2 cycles. The bank as a whole serves one op per cycle.
- Out-of-range: row>=DEPTH, col>=ROW_W, or col[log2(TX_W)-1:0]!=0.
  - Read returns all-zero data (initiators read row DEPTH as a padding row).
  - Write is dropped.
  - Still acked.
  - addr_err_out sets only for misalignment or col>=ROW_W; row==DEPTH is legal padding. Flag clears only on reset.
- Load: writes the array at the end of the cycle. Out-of-range loads are dropped and set addr_err_out.
- Load and granted write to the same chunk in one cycle cannot occur, since grants are blocked while load_en=1.
- A request dropped before ack is not an error. Since the grant is registered, an ack may still arrive one cycle later.
- rdata_out holds its last value when there is no read ack.

Optional Feature:
- Macro: GRID_BANK_STATS_EN.
- When defined, adds outputs:
  - stat_reads_out (32b): saturating count of acked reads.
  - stat_writes_out (32b): saturating count of acked writes.
  - stat_stall_out (32b): saturating count of cycles with at least one eligible port not granted.
  - Counters reset to 0 by reset_n.
- When undefined, these ports and the counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package grid_bank_pkg holds:
  - constants TX_W, ROW_W, DEPTH, CHUNKS_PER_ROW = ROW_W/TX_W;
  - typedef chunk_t (TX_W bits);
  - typedef req_op_e {OP_NONE, OP_READ, OP_WRITE};
  - function chunk_index(col).
- One sub-module, grid_rr_arbiter: eligibility mask in, one-hot grant out, internal pointer.

Test Plan:
- Load row 3 chunks {A,B,C}; port0 reads row3 col0/64/128 back-to-back → acks in cycles 2,4,6 with data A,B,C and no duplicate acks.
- Ports 0 and 1 both hold a read from cycle 0 → ack0@1, ack1@2, ack0@3, alternating; pointer fairness is verified.
- Port1 asserts write and read together, row 5 col 64, data 0xDEAD → one ack, write committed; a following read returns 0xDEAD.
- Port0 reads row DEPTH → data 0 and ack; addr_err_out stays 0. A read at col 32 → data 0, ack, addr_err_out=1.
- load_en held 3 cycles while port0 requests → no ack until the cycle after load_en drops, then ack with the loaded data.
- reset_n pulsed low mid-read → ack_out and rdata_out drop immediately; contents preserved, and a read after reset returns the prior data.
